// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage external SRAM controller.
package arm_mem_pkg;

    localparam int unsigned DATA_MEM_BASE_DEF = 1024;
    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam int unsigned SRAM_WORD_W       = SRAM_ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } sram_state_t;

    // Halfword address of one half of a 32-bit word.
    function automatic logic [SRAM_ADDR_W-1:0] sram_half_addr(
        input logic [SRAM_WORD_W-1:0] word,
        input logic                   hi
    );
        return {word, hi};
    endfunction

    function automatic logic is_wr_state(input sram_state_t s);
        return (s == WR_LO) || (s == WR_HI);
    endfunction

    function automatic logic is_access_state(input sram_state_t s);
        return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait counter: tc flags the last cycle of a WAIT_CYCLES-long state,
// near_tc flags the cycle before it.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc,
    output logic near_tc
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(WAIT_CYCLES - 1));

    generate
        if (WAIT_CYCLES >= 2) begin : g_near
            assign near_tc = (cnt == CNT_W'(WAIT_CYCLES - 2));
        end else begin : g_no_near
            assign near_tc = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sram_controller.sv
// MEM-stage word responder splitting each 32-bit access into two 16-bit SRAM accesses.
// Optional out-of-range address check enabled by defining SRAM_ADDR_CHECK_EN.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES   = 5,
    parameter int unsigned DATA_MEM_BASE = DATA_MEM_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read_en,
    input  logic                   mem_write_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic                   addr_err,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    sram_state_t state, state_next;

    logic [31:0]             off;
    logic [SRAM_WORD_W-1:0]  word;
    logic                    req;
    logic                    tc;
    logic                    near_tc;
    logic                    cnt_clear;
    logic                    cnt_en;

    logic                    dq_oe;
    logic [SRAM_DATA_W-1:0]  dq_out;

    logic [SRAM_ADDR_W-1:0]  addr_next;
    logic                    we_n_next;
    logic                    dq_oe_next;
    logic [SRAM_DATA_W-1:0]  dq_out_next;
    logic [31:0]             read_data_next;
    logic                    err_next;
    logic                    range_bad;

    assign off  = address - 32'(DATA_MEM_BASE);
    assign word = off[SRAM_ADDR_W:2];
    assign req  = mem_read_en | mem_write_en;

    logic unused_off;
    assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    assign range_bad = (address < 32'(DATA_MEM_BASE)) || (off[31:SRAM_ADDR_W+1] != '0);
`else
    assign range_bad = 1'b0;
`endif

    // The counter restarts whenever the state changes.
    assign cnt_clear = (state_next != state);
    assign cnt_en    = is_access_state(state);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .en      (cnt_en),
        .tc      (tc),
        .near_tc (near_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            read_data <= '0;
        end else begin
            state     <= state_next;
            SRAM_ADDR <= addr_next;
            SRAM_WE_N <= we_n_next;
            dq_oe     <= dq_oe_next;
            dq_out    <= dq_out_next;
            read_data <= read_data_next;
        end
    end

    always_comb begin
        state_next     = state;
        addr_next      = SRAM_ADDR;
        we_n_next      = 1'b1;
        dq_oe_next     = 1'b0;
        dq_out_next    = dq_out;
        read_data_next = read_data;
        err_next       = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (range_bad) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else if (mem_write_en) begin
                        state_next = WR_LO;
                    end else begin
                        state_next = RD_LO;
                    end
                end
            end
            RD_LO: begin
                if (tc) begin
                    state_next                       = RD_HI;
                    read_data_next[SRAM_DATA_W-1:0]  = SRAM_DQ;
                end
            end
            RD_HI: begin
                if (tc) begin
                    state_next                       = DONE;
                    read_data_next[31:SRAM_DATA_W]   = SRAM_DQ;
                end
            end
            WR_LO: begin
                if (tc) state_next = WR_HI;
            end
            WR_HI: begin
                if (tc) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Address is loaded once on entry to each half.
        if (state_next != state) begin
            case (state_next)
                RD_LO, WR_LO: addr_next = sram_half_addr(word, 1'b0);
                RD_HI, WR_HI: addr_next = sram_half_addr(word, 1'b1);
                default:      addr_next = SRAM_ADDR;
            endcase
        end

        // WE_N rises for the final cycle of each half so data is held across the edge.
        if (is_wr_state(state_next)) begin
            dq_oe_next  = 1'b1;
            dq_out_next = (state_next == WR_LO) ? write_data[SRAM_DATA_W-1:0]
                                                : write_data[31:SRAM_DATA_W];
            we_n_next   = (state_next != state) ? 1'(WAIT_CYCLES == 1) : near_tc;
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    logic addr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= err_next;
        end
    end

    assign addr_err = addr_err_q;
`else
    logic unused_err;
    assign unused_err = err_next;
    assign addr_err   = 1'b0;
`endif

    assign ready = ((state == IDLE) && !mem_read_en && !mem_write_en) || (state == DONE);

    assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural asynchronous SRAM.
module tb_sram_controller;

    localparam int unsigned WAIT = 5;
    localparam int          LAT  = 2 * WAIT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    logic [15:0] sram_mem [0:(1<<18)-1];
    logic        probe;
    logic        tb_drive;
    logic [15:0] tb_dq;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_rd_q [$];
    logic [33:0] exp_wr_q [$];
    logic [31:0] model_rd;

    int          we_low  = 0;
    logic        prev_we = 1'b1;
    logic [33:0] mon_e;

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES   (WAIT),
        .DATA_MEM_BASE (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .ready        (ready),
        .addr_err     (addr_err),
        .SRAM_DQ      (SRAM_DQ),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_WE_N    (SRAM_WE_N)
    );

    // SRAM drives reads; probe drives a marker to prove the DUT has released the bus.
    assign tb_drive = probe | (mem_read_en & ~mem_write_en);
    assign tb_dq    = probe ? 16'h5A5A : sram_mem[SRAM_ADDR];
    assign SRAM_DQ  = tb_drive ? tb_dq : 16'bz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: on each WE_N rise, compare against the expected-write queue.
    always @(negedge clk) begin
        if (rst) begin
            we_low  = 0;
            prev_we = 1'b1;
        end else begin
            if (prev_we == 1'b0 && SRAM_WE_N == 1'b1) begin
                check("we_low_cycles", 32'(we_low), 32'(WAIT - 1));
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(SRAM_ADDR), 32'(mon_e[33:16]));
                    check("wr_data", 32'(SRAM_DQ), 32'(mon_e[15:0]));
                end
                sram_mem[SRAM_ADDR] = SRAM_DQ;
                we_low = 0;
            end
            if (!SRAM_WE_N) we_low++;
            prev_we = SRAM_WE_N;
        end
    end

    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int exp_lat, input logic exp_err,
                          input logic from_idle, input logic release_req);
        int          cyc;
        logic [17:0] lo;
        lo = 18'(((addr - 32'd1024) >> 2) << 1);
        mem_write_en = wr;
        mem_read_en  = rd;
        address      = addr;
        write_data   = wdata;
        if (!exp_err && wr) begin
            exp_wr_q.push_back({lo, wdata[15:0]});
            exp_wr_q.push_back({lo | 18'd1, wdata[31:16]});
        end
        if (!exp_err && rd && !wr) model_rd = rdata;
        exp_rd_q.push_back(model_rd);
        if (from_idle) begin
            #1;
            check("ready_low_on_req", 32'(ready), 32'd0);
        end
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!ready && cyc < 60);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("read_data", read_data, exp_rd_q.pop_front());
        check("addr_err_done", 32'(addr_err), 32'(exp_err));
        if (release_req) begin
            mem_write_en = 1'b0;
            mem_read_en  = 1'b0;
            @(posedge clk);
            #1;
            check("ready_idle", 32'(ready), 32'd1);
            check("addr_err_idle", 32'(addr_err), 32'd0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        probe        = 1'b1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        address      = '0;
        write_data   = '0;
        model_rd     = '0;
        sram_mem[4]  = 16'h2222;
        sram_mem[5]  = 16'h1111;
        sram_mem[6]  = 16'h4444;
        sram_mem[7]  = 16'h3333;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'd0);
        check("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_dq_hiz", 32'(SRAM_DQ), 32'h5A5A);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        rst   = 1'b0;
        probe = 1'b0;
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0,        LAT,     1'b0, 1'b1, 1'b1);
        access(1'b0, 1'b1, 32'd1024, 32'd0,        32'hDEADBEEF, LAT,     1'b0, 1'b1, 1'b1);
        access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'd0,        LAT,     1'b0, 1'b1, 1'b1);
        access(1'b0, 1'b1, 32'd1032, 32'd0,        32'h11112222, LAT,     1'b0, 1'b1, 1'b0);
        access(1'b0, 1'b1, 32'd1036, 32'd0,        32'h33334444, LAT + 1, 1'b0, 1'b0, 1'b1);
        access(1'b0, 1'b1, 32'd1028, 32'd0,        32'hCAFEF00D, LAT,     1'b0, 1'b1, 1'b1);

`ifdef SRAM_ADDR_CHECK_EN
        access(1'b0, 1'b1, 32'd512, 32'd0, 32'd0, 1, 1'b1, 1'b1, 1'b1);
        check("err_sram_addr", 32'(SRAM_ADDR), 32'd3);
        check("err_we_n", 32'(SRAM_WE_N), 32'd1);
`endif

        // Reset during cycle 4 of a write.
        mem_write_en = 1'b1;
        address      = 32'd1040;
        write_data   = 32'h1234FFFF;
        repeat (4) @(posedge clk);
        #1;
        check("mid_we_low", 32'(SRAM_WE_N), 32'd0);
        rst   = 1'b1;
        probe = 1'b1;
        #1;
        check("rst_async_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_async_dq_hiz", 32'(SRAM_DQ), 32'h5A5A);
        check("rst_async_addr", 32'(SRAM_ADDR), 32'd0);
        @(negedge clk);
        #1;
        rst          = 1'b0;
        probe        = 1'b0;
        mem_write_en = 1'b0;
        #1;
        check("rst_ready_after", 32'(ready), 32'd1);
        check("rst_read_data_cleared", read_data, 32'd0);
        @(posedge clk);
        #1;
        check("rst_idle_ready", 32'(ready), 32'd1);
        check("rst_idle_we_n", 32'(SRAM_WE_N), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the ARMv5 pipeline's MEM stage. It accepts word read/write requests from the EXE/MEM pipeline register, decomposes each 32-bit access into two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low until the access completes. The top level uses `~ready` as the pipeline freeze. It replaces the single-cycle `Memory` instance between the EXE and MEM stage registers.

## Interface
- `WAIT_CYCLES`, 5: cycles spent on each 16-bit half access (≥1).
- `DATA_MEM_BASE`, 1024: byte address subtracted from `address` before mapping.
- `clk  in  1`: clock. All logic runs on the rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `mem_read_en  in  1`: read request. Held stable until `ready`.
- `mem_write_en  in  1`: write request. Held stable until `ready`.
- `address  in  32`: byte address (ALU result).
- `write_data  in  32`: store data (Rm value).
- `read_data  out  32`: registered load data.
- `ready  out  1`: access complete, or no request pending.
- `addr_err  out  1`: out-of-range access flag. Exists only under the macro; otherwise tied 0.
- `SRAM_DQ  inout  16`: SRAM data bus.
- `SRAM_ADDR  out  18`: SRAM halfword address.
- `SRAM_WE_N  out  1`: SRAM write enable, active-low.

## Operation
- Reset values:
  - FSM in IDLE, counter 0.
  - `read_data` 0, `SRAM_ADDR` 0, `SRAM_WE_N` 1, `SRAM_DQ` hi-Z, `addr_err` 0.
- Address map:
  - `off = address - DATA_MEM_BASE`.
  - `word = off[18:2]`.
  - Low half at `{word,1'b0}`, high half at `{word,1'b1}`.
  - `off[1:0]` is ignored.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE transitions:
  - `mem_write_en` → WR_LO. Write has priority if both enables are high.
  - Else `mem_read_en` → RD_LO.
  - Else stay in IDLE.
- Each LO/HI state lasts exactly `WAIT_CYCLES` cycles, counted by the wait counter.
  - LO → HI on terminal count.
  - HI → DONE on terminal count.
- DONE → IDLE unconditionally, after 1 cycle.
- Read path:
  - `SRAM_DQ` is hi-Z.
  - Sample `SRAM_DQ` into `read_data[15:0]` on the last RD_LO cycle and into `read_data[31:16]` on the last RD_HI cycle.
  - `read_data` holds until the next read completes. Writes do not change it.
- Write path:
  - `SRAM_DQ` drives `write_data[15:0]` in WR_LO and `write_data[31:16]` in WR_HI.
  - `SRAM_WE_N` = 0 in every WR_LO/WR_HI cycle except the last cycle of each, giving data hold on the WE_N rising edge.
- `SRAM_ADDR` is registered and loaded on entry to each LO/HI state.
- `ready`:
  - Combinational: `(state==IDLE & ~mem_read_en & ~mem_write_en) | state==DONE`.
  - Low in the IDLE cycle in which a request is first seen.
- A request still asserted in the cycle after DONE is treated as a new access. The requester must advance on the `ready` edge.

## Timing
- Latency: request first seen in IDLE at cycle 0 → `ready`=1 at cycle 2·`WAIT_CYCLES`+1 (11 with the default).
- `read_data` is valid in the DONE cycle (same cycle as `ready`).
- Throughput: one access per 2·`WAIT_CYCLES`+2 cycles for back-to-back requests.
- Reset mid-access:
  - Immediate return to IDLE; `SRAM_WE_N` goes to 1 and `SRAM_DQ` to hi-Z asynchronously.
  - Any partial write is lost and partial read data is discarded (`read_data` = 0).
- Request deasserted mid-access: the access completes anyway. This is illegal stimulus, but the behaviour is defined.
- Counter wraps to 0 on each state change. Width is `$clog2(WAIT_CYCLES+1)`.

## Configuration
- Macro: `SRAM_ADDR_CHECK_EN`.
- Defined:
  - In IDLE, a request with `address < DATA_MEM_BASE` or `off ≥ 2^19` goes directly to DONE with no SRAM activity.
  - `addr_err`=1 during that DONE cycle only.
  - An erroring read leaves `read_data` unchanged.
- Undefined:
  - No check; `off` wraps modulo 2^19.
  - `addr_err` is constant 0.

## Structure
- Shared package `arm_mem_pkg`:
  - State enum `sram_state_t`.
  - Constants `DATA_MEM_BASE_DEF`=1024, `SRAM_ADDR_W`=18, `SRAM_DATA_W`=16.
- One sub-module, `sram_wait_counter`:
  - Inputs: `clk`, `rst`, `clear`, `en`.
  - Output: `tc` (terminal count at `WAIT_CYCLES`-1).
- Tri-state driver stays in the top of the block.

## Test plan
- Write `address`=1024, `write_data`=0xDEADBEEF:
  - `SRAM_ADDR` 0 then 1 with DQ 0xBEEF then 0xDEAD.
  - `ready` at cycle 11.
- Read back from 1024 with the SRAM model → `read_data`=0xDEADBEEF and `ready` in the same cycle, cycle 11.
- Both enables high, `address`=1028 → write performed at `SRAM_ADDR` 2/3; `read_data` unchanged.
- Back-to-back reads at 1032 and 1036 (data 0x11112222, 0x33334444) → two `ready` pulses 12 cycles apart with correct data.
- Assert `rst` at cycle 4 of a write → `SRAM_WE_N`=1 and DQ hi-Z immediately; IDLE; `ready`=1 once the request drops.
- With `SRAM_ADDR_CHECK_EN`, read `address`=512 → `ready` at cycle 1, `addr_err`=1 for one cycle, no `SRAM_WE_N`/`SRAM_ADDR` activity.
